// File: rtl/reg_bus_arb_if.sv
// reg_bus_arb_if: two requester ports plus the shared register bus of the arbiter
interface reg_bus_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              m0_req, m0_wr, m0_ack, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_wr, m1_ack, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              sel, wr, ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata, m1_req, m1_wr, m1_addr, m1_wdata, rdata, ready,
        output m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, sel, wr, addr, wdata
    );
    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata, m1_req, m1_wr, m1_addr, m1_wdata, rdata, ready,
        input  m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, sel, wr, addr, wdata
    );
endinterface

// File: rtl/reg_bus_arb.sv
// reg_bus_arb: round-robin arbiter of two requesters onto one register bus with timeout abort
module reg_bus_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    reg_bus_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t            state, state_nx;
    logic              gnt, last, lat_wr, err0, err1;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, rdata0, rdata1, resp;
    logic [7:0]        cnt;
    logic              win, grant, done, abort;
    always_comb begin
        win      = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
        grant    = state == IDLE && (bus.m0_req || bus.m1_req);
        done     = state == BUSY && bus.ready;
        abort    = state == BUSY && !bus.ready && cnt == 8'(TIMEOUT - 1);
        resp     = abort ? '1 : (lat_wr ? '0 : bus.rdata);
        state_nx = state == IDLE ? (grant ? BUSY : IDLE) :
                   state == BUSY ? ((done || abort) ? ACK : BUSY) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state == BUSY ? cnt + 8'd1 : '0;
            if (grant) begin
                gnt       <= win;
                last      <= win;
                lat_wr    <= win ? bus.m1_wr : bus.m0_wr;
                lat_addr  <= win ? bus.m1_addr : bus.m0_addr;
                lat_wdata <= win ? bus.m1_wdata : bus.m0_wdata;
            end
            // per-port response registers double as the held output values
            if ((done || abort) && !gnt) begin
                rdata0 <= resp;
                err0   <= abort;
            end
            if ((done || abort) && gnt) begin
                rdata1 <= resp;
                err1   <= abort;
            end
        end
    end
    assign bus.sel      = state == BUSY;
    assign bus.wr       = lat_wr;
    assign bus.addr     = lat_addr;
    assign bus.wdata    = lat_wdata;
    assign bus.m0_ack   = state == ACK && !gnt;
    assign bus.m1_ack   = state == ACK && gnt;
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
    assign bus.m0_err   = err0;
    assign bus.m1_err   = err1;
endmodule

// File: tb/tb_reg_bus_arb.sv
// tb_reg_bus_arb: vector table, corner sequences and random transfers against a transaction model
module tb_reg_bus_arb;
    localparam int AW = 8, DW = 16, TO = 64;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    reg_bus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    reg_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0, errors = 0;
    typedef struct {
        logic r0, r1, wr0, wr1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        int n;
        logic [DW-1:0] rd;
        int port, selc;
        logic [DW-1:0] rdv;
        logic err;
    } vec_t;
    vec_t tbl [7];
    logic [DW-1:0] hold_rd [2];
    logic hold_err [2];
    int mlast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {bus.m0_req, bus.m1_req, bus.m0_wr, bus.m1_wr, bus.ready} = '0;
        {bus.m0_addr, bus.m1_addr, bus.m0_wdata, bus.m1_wdata, bus.rdata} = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_rd[0] = '0; hold_rd[1] = '0; hold_err[0] = 1'b0; hold_err[1] = 1'b0;
        mlast = 1;
    endtask

    // starts and ends at a negedge with the arbiter in IDLE
    task automatic do_row(input vec_t v, input string tag);
        int selc = 0, lat = 0, port = -1;
        logic [DW-1:0] rdv = 'x;
        logic errv = 1'bx, swr = 1'b0;
        logic [AW-1:0] sa = '0;
        logic [DW-1:0] sd = '0;
        bit stable = 1, both = 0, selack = 0;
        bus.m0_req = v.r0; bus.m0_wr = v.wr0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
        bus.m1_req = v.r1; bus.m1_wr = v.wr1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
        for (int c = 1; c <= TO + 8 && port < 0; c++) begin
            @(negedge clk);
            if (bus.sel) begin
                if (selc == 0) {swr, sa, sd} = {bus.wr, bus.addr, bus.wdata};
                else if ({bus.wr, bus.addr, bus.wdata} != {swr, sa, sd}) stable = 0;
                selc++;
            end
            if (bus.m0_ack && bus.m1_ack) both = 1;
            if (bus.m0_ack || bus.m1_ack) begin
                port   = bus.m1_ack ? 1 : 0;
                lat    = c;
                selack = bus.sel;
                rdv    = bus.m1_ack ? bus.m1_rdata : bus.m0_rdata;
                errv   = bus.m1_ack ? bus.m1_err : bus.m0_err;
            end
            bus.ready = bus.sel ? (selc - 1 >= v.n) : 1'($urandom);
            bus.rdata = (bus.sel && bus.ready) ? v.rd : DW'($urandom);
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        chk({tag, " port"}, port, v.port);
        chk({tag, " sel_cycles"}, selc, v.selc);
        chk({tag, " latency"}, lat, v.selc + 1);
        chk({tag, " rdata"}, rdv, v.rdv);
        chk({tag, " err"}, errv, v.err);
        chk({tag, " both_ack"}, both, 0);
        chk({tag, " sel_in_ack"}, selack, 0);
        chk({tag, " bus_stable"}, stable, 1);
        chk({tag, " bus_wr"}, swr, v.port ? v.wr1 : v.wr0);
        chk({tag, " bus_addr"}, sa, v.port ? v.a1 : v.a0);
        chk({tag, " bus_wdata"}, sd, v.port ? v.d1 : v.d0);
        hold_rd[v.port] = v.rdv;
        hold_err[v.port] = v.err;
        @(negedge clk);
        chk({tag, " hold_rdata0"}, bus.m0_rdata, hold_rd[0]);
        chk({tag, " hold_rdata1"}, bus.m1_rdata, hold_rd[1]);
        chk({tag, " hold_err0"}, bus.m0_err, hold_err[0]);
        chk({tag, " hold_err1"}, bus.m1_err, hold_err[1]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int order [$];
        int both, selc, acks;
        vec_t v;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hBE, 8'h00, 16'hBC7A, 16'h0000, 0, 16'h5555, 0, 1, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h57, 16'h0000, 16'h0000, 3, 16'h1234, 1, 4, 16'h1234, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 16'h0AAA, 16'h2222, 1, 16'hABCD, 0, 2, 16'hABCD, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 16'h0AAA, 16'h2222, 0, 16'h7777, 1, 1, 16'h0000, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 16'h0000, 16'h0000, 63, 16'hCAFE, 1, 64, 16'hCAFE, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00, 16'h0000, 16'h0000, 200, 16'h9999, 0, 64, 16'hFFFF, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 16'h3333, 16'h1111, 2, 16'h0000, 1, 3, 16'h0000, 1'b0};
        rst = 1'b1;
        @(negedge clk);
        chk("reset sel", bus.sel, 0);
        chk("reset wr", bus.wr, 0);
        chk("reset addr", bus.addr, 0);
        chk("reset wdata", bus.wdata, 0);
        chk("reset acks", {bus.m0_ack, bus.m1_ack}, 0);
        chk("reset errs", {bus.m0_err, bus.m1_err}, 0);
        chk("reset rdata0", bus.m0_rdata, 0);
        chk("reset rdata1", bus.m1_rdata, 0);
        do_reset();
        foreach (tbl[i]) do_row(tbl[i], $sformatf("vec%0d", i));

        do_reset();
        bus.m0_wr = 1'b1; bus.m0_addr = 8'h01; bus.m0_wdata = 16'h0101;
        bus.m1_wr = 1'b1; bus.m1_addr = 8'h02; bus.m1_wdata = 16'h0202;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.ready = 1'b1;
        both = 0; selc = 0;
        for (int c = 0; c < 200 && order.size() < 8; c++) begin
            @(negedge clk);
            if (bus.m0_ack && bus.m1_ack) both++;
            if (bus.sel) selc++;
            if (bus.m0_ack || bus.m1_ack) order.push_back(bus.m1_ack ? 1 : 0);
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.ready = 1'b0;
        chk("contend ack_count", order.size(), 8);
        chk("contend both_ack", both, 0);
        chk("contend sel_cycles", selc, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("contend order%0d", i), i < order.size() ? order[i] : -1, i % 2);

        do_reset();
        bus.m0_req = 1'b1; bus.m0_wr = 1'b1; bus.m0_addr = 8'h77; bus.m0_wdata = 16'h4242;
        @(negedge clk);
        chk("midbusy sel_first", bus.sel, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midbusy sel_reset", bus.sel, 0);
        bus.m0_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            acks += int'(bus.m0_ack) + int'(bus.m1_ack);
        end
        rst = 1'b0;
        @(negedge clk);
        acks += int'(bus.m0_ack) + int'(bus.m1_ack);
        chk("midbusy no_ack", acks, 0);
        chk("midbusy sel_after", bus.sel, 0);
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h78, 8'h00, 16'h5151, 16'h0000, 1, 16'h0BAD, 0, 2, 16'h0000, 1'b0};
        do_row(v, "after_reset");

        do_reset();
        for (int k = 0; k < 150; k++) begin
            bit tout;
            v.r0 = 1'($urandom);
            v.r1 = v.r0 ? 1'($urandom) : 1'b1;
            v.wr0 = 1'($urandom); v.wr1 = 1'($urandom);
            v.a0 = AW'($urandom); v.a1 = AW'($urandom);
            v.d0 = DW'($urandom); v.d1 = DW'($urandom);
            v.rd = DW'($urandom);
            v.n = ($urandom % 16 == 0) ? int'($urandom_range(TO - 2, TO + 5)) : int'($urandom_range(0, 6));
            // tie goes to whichever port was not granted last
            v.port = (v.r0 && v.r1) ? 1 - mlast : (v.r0 ? 0 : 1);
            mlast = v.port;
            tout = v.n >= TO;
            v.selc = tout ? TO : v.n + 1;
            v.err = tout;
            v.rdv = tout ? {DW{1'b1}} : ((v.port ? v.wr1 : v.wr0) ? '0 : v.rd);
            do_row(v, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
